// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin bus arbiter.
// Pure declarations; no timing or flow-control content.
package arb_pkg;

    localparam int ARB_N_REQ = 4;
    localparam int ARB_IDX_W = 2;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_RECOVER = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first requester after last_owner, wrapping; combinational,
// zero latency, no flow control (pure function of its inputs).
module rr_pick
    import arb_pkg::*;
#(
    parameter int N_REQ = ARB_N_REQ,
    parameter int IDX_W = ARB_IDX_W
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_owner,
    output logic             any,
    output logic [IDX_W-1:0] winner_idx
);

    logic [IDX_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit is the one left standing.
    always_comb begin
        any        = |req;
        winner_idx = last_owner;
        cand       = last_owner;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_owner) + k) % N_REQ);
            if (req[cand]) begin
                winner_idx = cand;
            end
        end
    end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter with max-tenure preemption; grant appears 1 cycle after request,
// 1 turnaround cycle between tenures; no backpressure, requests are levels held by masters.
module rr_bus_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = ARB_N_REQ,
    parameter int IDX_W    = ARB_IDX_W,
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic [N_REQ-1:0] req,
    input  logic             bus_release,
    output logic             gnt_vld,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             timeout
);

    localparam logic [IDX_W-1:0]  LAST_RST  = IDX_W'(N_REQ - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
    localparam bit                PREEMPT_EN = (MAX_HOLD != 0);

    arb_state_t       state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [IDX_W-1:0] last_owner, last_nxt;
    logic [IDX_W-1:0] gnt_idx_nxt;
    logic             gnt_vld_nxt;
    logic             timeout_nxt;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic [N_REQ-1:0] owner_mask;
    logic             owner_req;
    logic             other_req;
    logic             expired;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (req),
        .last_owner (last_owner),
        .any        (pick_any),
        .winner_idx (pick_idx)
    );

    always_comb begin
        owner_mask          = '0;
        owner_mask[gnt_idx] = 1'b1;
        owner_req           = |(req & owner_mask);
        other_req           = |(req & ~owner_mask);
        // Counter saturates, so ">=" lets a late-arriving requester preempt immediately.
        expired             = PREEMPT_EN && (hold_cnt >= HOLD_LAST);
    end

    always_comb begin
        state_nxt   = state;
        gnt_vld_nxt = gnt_vld;
        gnt_idx_nxt = gnt_idx;
        timeout_nxt = 1'b0;
        hold_nxt    = hold_cnt;
        last_nxt    = last_owner;

        case (state)
            ARB_IDLE, ARB_RECOVER: begin
                gnt_vld_nxt = 1'b0;
                state_nxt   = ARB_IDLE;
                if (pick_any) begin
                    state_nxt   = ARB_GRANT;
                    gnt_vld_nxt = 1'b1;
                    gnt_idx_nxt = pick_idx;
                    hold_nxt    = '0;
                end
            end

            ARB_GRANT: begin
                if (hold_cnt != HOLD_MAX) begin
                    hold_nxt = hold_cnt + 1'b1;
                end
                if (bus_release || !owner_req) begin
                    state_nxt   = ARB_RECOVER;
                    gnt_vld_nxt = 1'b0;
                    last_nxt    = gnt_idx;
                end else if (expired && other_req) begin
                    state_nxt   = ARB_RECOVER;
                    gnt_vld_nxt = 1'b0;
                    last_nxt    = gnt_idx;
                    timeout_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt   = ARB_IDLE;
                gnt_vld_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state      <= ARB_IDLE;
            gnt_vld    <= 1'b0;
            gnt_idx    <= '0;
            timeout    <= 1'b0;
            hold_cnt   <= '0;
            last_owner <= LAST_RST;
        end else begin
            state      <= state_nxt;
            gnt_vld    <= gnt_vld_nxt;
            gnt_idx    <= gnt_idx_nxt;
            timeout    <= timeout_nxt;
            hold_cnt   <= hold_nxt;
            last_owner <= last_nxt;
        end
    end

endmodule
